// File: rtl/ga_sync_irq_pkg.sv
// Shared constants and state types for the Gate Array sync/interrupt stage.
package ga_pkg;

    // Timing defaults
    localparam int IRQ_LINES = 52;  // R52 terminal count
    localparam int HS_DELAY  = 2;   // CLKEN ticks from HSYNC rise to HSYNC_OUT rise
    localparam int HS_WIDTH  = 4;   // maximum HSYNC_OUT width in CLKEN ticks
    localparam int VS_DELAY  = 2;   // HSYNC falls after VSYNC rise before VSYNC_OUT
    localparam int VS_WIDTH  = 4;   // VSYNC_OUT width in HSYNC falls

    // RMR field positions
    localparam int RMR_CLR_BIT  = 4;
    localparam int RMR_MODE_LSB = 0;

    // Screen mode encodings
    localparam logic [1:0] MODE0 = 2'd0;
    localparam logic [1:0] MODE1 = 2'd1;
    localparam logic [1:0] MODE2 = 2'd2;
    localparam logic [1:0] MODE3 = 2'd3;

    // HSYNC shaper: waiting for the delay to expire, then emitting the pulse
    typedef enum logic [1:0] {
        SHP_IDLE  = 2'd0,
        SHP_DELAY = 2'd1,
        SHP_PULSE = 2'd2
    } shp_state_t;

    // VSYNC path: armed counts lines up to the delay, active counts the width
    typedef enum logic [1:0] {
        VS_IDLE   = 2'd0,
        VS_ARMED  = 2'd1,
        VS_ACTIVE = 2'd2
    } vs_state_t;

endpackage

// File: rtl/ga_sync_irq_shaper.sv
// Delay + width shaper turning the CRTC HSYNC into the monitor HSYNC pulse.
// The pulse is "state == SHP_PULSE", so the state output doubles as the
// registered pulse and as a debug view of the shaper.
module ga_sync_shaper
    import ga_pkg::*;
#(
    parameter int DELAY = HS_DELAY,
    parameter int WIDTH = HS_WIDTH
)
(
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       CLKEN,
    input  logic       SYNC_IN,    // raw CRTC sync, only looked at on CLKEN
    input  logic       SYNC_RISE,  // CLKEN-qualified rise of SYNC_IN
    output logic       OUT_RISE,   // strobe on the tick where the pulse starts
    output shp_state_t STATE
);

    localparam logic [3:0] DELAY_L = 4'(DELAY);
    localparam logic [3:0] WIDTH_L = 4'(WIDTH);

    shp_state_t state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    // State and tick counter register
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            STATE <= SHP_IDLE;
            cnt   <= 4'd0;
        end else begin
            STATE <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: a new rise always restarts the delay; a low sync ends shaping
    always_comb begin
        state_nxt = STATE;
        cnt_nxt   = cnt;
        OUT_RISE  = 1'b0;
        if (CLKEN) begin
            if (SYNC_RISE) begin
                state_nxt = SHP_DELAY;
                cnt_nxt   = DELAY_L;
            end else begin
                case (STATE)
                    SHP_DELAY: begin
                        if (!SYNC_IN) begin
                            state_nxt = SHP_IDLE;
                            cnt_nxt   = 4'd0;
                        end else if (cnt <= 4'd1) begin
                            state_nxt = SHP_PULSE;
                            cnt_nxt   = WIDTH_L;
                            OUT_RISE  = 1'b1;
                        end else begin
                            cnt_nxt = cnt - 4'd1;
                        end
                    end
                    SHP_PULSE: begin
                        if (!SYNC_IN || cnt <= 4'd1) begin
                            state_nxt = SHP_IDLE;
                            cnt_nxt   = 4'd0;
                        end else begin
                            cnt_nxt = cnt - 4'd1;
                        end
                    end
                    default: begin
                        state_nxt = STATE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/ga_sync_irq.sv
// Gate Array sync/interrupt stage: shapes CRTC syncs for the monitor, runs the
// 52-line raster interrupt counter and latches the screen mode at HSYNC.
//
// Pulse inputs: IRQ_ACK and RMR_WR are single-CLOCK strobes that act on the
// cycle they are high, independent of CLKEN. There is no backpressure anywhere.
module ga_sync_irq
    import ga_pkg::*;
(
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       CLKEN,
    input  logic       HSYNC,
    input  logic       VSYNC,
    input  logic       IRQ_ACK,
    input  logic       RMR_WR,
    input  logic [4:0] RMR_DI,
    output logic       HSYNC_OUT,
    output logic       VSYNC_OUT,
    output logic       INT,
    output logic [1:0] MODE,
    output logic [5:0] R52
);

    localparam logic [5:0] IRQ_LINES_L = 6'(IRQ_LINES);
    localparam logic [3:0] VS_DELAY_L  = 4'(VS_DELAY);
    localparam logic [3:0] VS_WIDTH_L  = 4'(VS_WIDTH);

    logic       hs_prev;
    logic       vs_prev;
    logic       hs_rise;
    logic       hs_fall;
    logic       vs_rise;
    logic       mode_strobe;
    shp_state_t shp_state;
    logic [1:0] pend_mode;
    vs_state_t  vs_state;
    vs_state_t  vs_state_nxt;
    logic [3:0] vs_cnt;
    logic [3:0] vs_cnt_nxt;
    logic [3:0] vs_cnt_inc;
    logic       vs_force;
    logic [5:0] r52_nxt;
    logic [5:0] r52_inc;
    logic       int_nxt;
    logic       rmr_clr;
    logic       rmr_unused;

    assign hs_rise    = CLKEN & HSYNC & ~hs_prev;
    assign hs_fall    = CLKEN & ~HSYNC & hs_prev;
    assign vs_rise    = CLKEN & VSYNC & ~vs_prev;
    assign rmr_clr    = RMR_WR & RMR_DI[RMR_CLR_BIT];
    assign rmr_unused = ^RMR_DI[3:2];
    assign vs_cnt_inc = vs_cnt + 4'd1;
    assign r52_inc    = R52 + 6'd1;

    // Previous CRTC sync samples, taken only on character ticks
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else if (CLKEN) begin
            hs_prev <= HSYNC;
            vs_prev <= VSYNC;
        end
    end

    ga_sync_shaper #(
        .DELAY (HS_DELAY),
        .WIDTH (HS_WIDTH)
    ) u_hs_shaper (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .CLKEN     (CLKEN),
        .SYNC_IN   (HSYNC),
        .SYNC_RISE (hs_rise),
        .OUT_RISE  (mode_strobe),
        .STATE     (shp_state)
    );

    assign HSYNC_OUT = (shp_state == SHP_PULSE);

    // Pending mode follows RMR writes; effective mode updates at HSYNC_OUT rise
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            pend_mode <= MODE0;
            MODE      <= MODE0;
        end else begin
            if (RMR_WR) begin
                pend_mode <= RMR_DI[RMR_MODE_LSB +: 2];
            end
            if (mode_strobe) begin
                MODE <= pend_mode;
            end
        end
    end

    // VSYNC line counter register
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            vs_state <= VS_IDLE;
            vs_cnt   <= 4'd0;
        end else begin
            vs_state <= vs_state_nxt;
            vs_cnt   <= vs_cnt_nxt;
        end
    end

    // VSYNC path: counts HSYNC falls; re-rises while armed/active are ignored
    always_comb begin
        vs_state_nxt = vs_state;
        vs_cnt_nxt   = vs_cnt;
        vs_force     = 1'b0;
        case (vs_state)
            VS_IDLE: begin
                if (vs_rise) begin
                    vs_state_nxt = VS_ARMED;
                    vs_cnt_nxt   = 4'd0;
                end
            end
            VS_ARMED: begin
                if (hs_fall) begin
                    if (vs_cnt_inc == VS_DELAY_L) begin
                        vs_state_nxt = VS_ACTIVE;
                        vs_cnt_nxt   = 4'd0;
                        vs_force     = 1'b1;
                    end else begin
                        vs_cnt_nxt = vs_cnt_inc;
                    end
                end
            end
            VS_ACTIVE: begin
                if (hs_fall) begin
                    if (vs_cnt_inc == VS_WIDTH_L) begin
                        vs_state_nxt = VS_IDLE;
                        vs_cnt_nxt   = 4'd0;
                    end else begin
                        vs_cnt_nxt = vs_cnt_inc;
                    end
                end
            end
            default: begin
                vs_state_nxt = VS_IDLE;
                vs_cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign VSYNC_OUT = (vs_state == VS_ACTIVE);

    // Interrupt counter and request register
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            R52 <= 6'd0;
            INT <= 1'b0;
        end else begin
            R52 <= r52_nxt;
            INT <= int_nxt;
        end
    end

    // RMR clear beats ack beats line counting; the VSYNC force beats terminal count
    always_comb begin
        r52_nxt = R52;
        int_nxt = INT;
        if (rmr_clr) begin
            r52_nxt = 6'd0;
            int_nxt = 1'b0;
        end else if (IRQ_ACK) begin
            r52_nxt = {1'b0, R52[4:0]};
            int_nxt = 1'b0;
        end else if (hs_fall) begin
            if (vs_force) begin
                if (R52[5]) begin
                    int_nxt = 1'b1;
                end
                r52_nxt = 6'd0;
            end else if (r52_inc == IRQ_LINES_L) begin
                r52_nxt = 6'd0;
                int_nxt = 1'b1;
            end else begin
                r52_nxt = r52_inc;
            end
        end
    end

endmodule

// File: tb/tb_ga_sync_irq.sv
// Bench for ga_sync_irq: directed CRTC line patterns, expected snapshots and
// HSYNC_OUT pulse shapes queued by the driver and checked by monitors.
module tb_ga_sync_irq;
    import ga_pkg::*;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       CLKEN;
    logic       HSYNC;
    logic       VSYNC;
    logic       IRQ_ACK;
    logic       RMR_WR;
    logic [4:0] RMR_DI;
    logic       HSYNC_OUT;
    logic       VSYNC_OUT;
    logic       INT;
    logic [1:0] MODE;
    logic [5:0] R52;

    int checks   = 0;
    int failures = 0;

    // Snapshot layout {HSYNC_OUT, VSYNC_OUT, INT, MODE[1:0], R52[5:0]}
    localparam logic [10:0] M_ALL  = 11'h7FF;
    localparam logic [10:0] M_HSO  = 11'h400;
    localparam logic [10:0] M_VSO  = 11'h200;
    localparam logic [10:0] M_INT  = 11'h100;
    localparam logic [10:0] M_MODE = 11'h0C0;
    localparam logic [10:0] M_R52  = 11'h03F;

    logic [10:0] exp_q[$];
    logic [10:0] msk_q[$];
    string       tag_q[$];
    logic [7:0]  pulse_q[$];   // {delay[3:0], width[3:0]}

    logic [10:0] snap;
    assign snap = {HSYNC_OUT, VSYNC_OUT, INT, MODE, R52};

    // Clock
    always #5 CLOCK = ~CLOCK;

    ga_sync_irq dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .CLKEN     (CLKEN),
        .HSYNC     (HSYNC),
        .VSYNC     (VSYNC),
        .IRQ_ACK   (IRQ_ACK),
        .RMR_WR    (RMR_WR),
        .RMR_DI    (RMR_DI),
        .HSYNC_OUT (HSYNC_OUT),
        .VSYNC_OUT (VSYNC_OUT),
        .INT       (INT),
        .MODE      (MODE),
        .R52       (R52)
    );

    function automatic logic [10:0] st(input logic hso, input logic vso, input logic irq,
                                       input logic [1:0] md, input logic [5:0] r);
        return {hso, vso, irq, md, r};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input logic hs, input logic vs);
        @(posedge CLOCK); #1;
        HSYNC = hs;
        VSYNC = vs;
        CLKEN = 1'b1;
        @(posedge CLOCK); #1;
        CLKEN = 1'b0;
    endtask

    task automatic tick_rmr(input logic hs, input logic vs, input logic [4:0] d);
        @(posedge CLOCK); #1;
        HSYNC  = hs;
        VSYNC  = vs;
        CLKEN  = 1'b1;
        RMR_WR = 1'b1;
        RMR_DI = d;
        @(posedge CLOCK); #1;
        CLKEN  = 1'b0;
        RMR_WR = 1'b0;
    endtask

    // One CRTC line; exp_w is the hand-computed HSYNC_OUT width (0 = none)
    task automatic line(input int len, input int hw, input logic vs, input int exp_w);
        if (exp_w > 0) pulse_q.push_back({4'(HS_DELAY), 4'(exp_w)});
        for (int i = 0; i < len; i++) tick(i < hw, vs);
    endtask

    task automatic lines(input int n);
        repeat (n) line(16, 6, 1'b0, 4);
    endtask

    task automatic rmr_write(input logic [4:0] d);
        @(posedge CLOCK); #1;
        RMR_WR = 1'b1;
        RMR_DI = d;
        @(posedge CLOCK); #1;
        RMR_WR = 1'b0;
    endtask

    task automatic irq_ack();
        @(posedge CLOCK); #1;
        IRQ_ACK = 1'b1;
        @(posedge CLOCK); #1;
        IRQ_ACK = 1'b0;
    endtask

    task automatic expect_st(input string t, input logic [10:0] m, input logic [10:0] v);
        exp_q.push_back(v);
        msk_q.push_back(m);
        tag_q.push_back(t);
    endtask

    // ---------------- snapshot monitor ----------------
    always @(negedge CLOCK) begin
        while (exp_q.size() > 0) begin
            logic [10:0] e;
            logic [10:0] m;
            string       t;
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if ((snap & m) !== (e & m)) begin
                failures++;
                $display("FAIL %s: got=%03h want=%03h mask=%03h (hso vso int mode r52 = %b %b %b %0d %0d)",
                         t, snap & m, e & m, m, HSYNC_OUT, VSYNC_OUT, INT, MODE, R52);
            end
        end
    end

    // ---------------- HSYNC_OUT pulse monitor ----------------
    logic tick_done = 1'b0;
    always @(posedge CLOCK) tick_done <= CLKEN;

    int   tcount   = 0;
    int   hs_t0    = 0;
    int   p_t0     = 0;
    int   p_w      = 0;
    logic hs_seen  = 1'b0;
    logic hso_seen = 1'b0;

    always @(negedge CLOCK) begin
        if (tick_done && !RESET) begin
            tcount++;
            if (HSYNC && !hs_seen) hs_t0 = tcount;
            hs_seen = HSYNC;
            if (HSYNC_OUT) begin
                if (!hso_seen) begin
                    p_t0 = tcount;
                    p_w  = 0;
                end
                p_w++;
            end else if (hso_seen) begin
                logic [7:0] got;
                logic [7:0] want;
                got = {4'(p_t0 - hs_t0), 4'(p_w)};
                checks++;
                if (pulse_q.size() == 0) begin
                    failures++;
                    $display("FAIL hso_pulse: unexpected pulse delay=%0d width=%0d", got[7:4], got[3:0]);
                end else begin
                    want = pulse_q.pop_front();
                    if (got !== want) begin
                        failures++;
                        $display("FAIL hso_pulse: got delay=%0d width=%0d want delay=%0d width=%0d",
                                 got[7:4], got[3:0], want[7:4], want[3:0]);
                    end
                end
            end
            hso_seen = HSYNC_OUT;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: stimulus did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        RESET   = 1'b1;
        CLKEN   = 1'b0;
        HSYNC   = 1'b0;
        VSYNC   = 1'b0;
        IRQ_ACK = 1'b0;
        RMR_WR  = 1'b0;
        RMR_DI  = 5'd0;
        repeat (3) @(posedge CLOCK);
        #1;
        expect_st("reset_state", M_ALL, st(0, 0, 0, 2'd0, 6'd0));
        @(posedge CLOCK); #1;
        RESET = 1'b0;

        // HSYNC shaping: widths 14, 3, 2
        line(64, 14, 1'b0, 4);
        expect_st("hs14_r52", M_R52 | M_INT | M_VSO, st(0, 0, 0, 2'd0, 6'd1));
        line(64, 3, 1'b0, 1);
        expect_st("hs3_r52", M_R52, st(0, 0, 0, 2'd0, 6'd2));
        line(64, 2, 1'b0, 0);
        expect_st("hs2_r52", M_R52 | M_HSO, st(0, 0, 0, 2'd0, 6'd3));

        // 52-line interrupt
        rmr_write(5'h10);
        expect_st("rmr_clr0", M_R52 | M_INT, st(0, 0, 0, 2'd0, 6'd0));
        lines(51);
        expect_st("line51", M_R52 | M_INT, st(0, 0, 0, 2'd0, 6'd51));
        lines(1);
        expect_st("line52_int", M_R52 | M_INT, st(0, 0, 1, 2'd0, 6'd0));
        irq_ack();
        expect_st("ack52", M_R52 | M_INT, st(0, 0, 0, 2'd0, 6'd0));

        // VSYNC with R52=40 -> interrupt on forced reset
        lines(40);
        expect_st("r52_40", M_R52, st(0, 0, 0, 2'd0, 6'd40));
        line(16, 6, 1'b1, 4);
        expect_st("vs40_l1", M_R52 | M_INT | M_VSO, st(0, 0, 0, 2'd0, 6'd41));
        line(16, 6, 1'b1, 4);
        expect_st("vs40_l2", M_R52 | M_INT | M_VSO, st(0, 1, 1, 2'd0, 6'd0));
        line(16, 6, 1'b0, 4);
        expect_st("vs40_l3", M_R52 | M_VSO, st(0, 1, 1, 2'd0, 6'd1));
        line(16, 6, 1'b1, 4);
        expect_st("vs40_l4_rerise", M_R52 | M_VSO, st(0, 1, 1, 2'd0, 6'd2));
        line(16, 6, 1'b0, 4);
        expect_st("vs40_l5", M_R52 | M_VSO, st(0, 1, 1, 2'd0, 6'd3));
        line(16, 6, 1'b0, 4);
        expect_st("vs40_l6_end", M_R52 | M_VSO | M_INT, st(0, 0, 1, 2'd0, 6'd4));
        lines(2);
        expect_st("vs40_no_rearm", M_R52 | M_VSO, st(0, 0, 1, 2'd0, 6'd6));
        irq_ack();
        expect_st("vs40_ack", M_R52 | M_INT, st(0, 0, 0, 2'd0, 6'd6));

        // VSYNC with R52=20 -> no interrupt, then 52 lines later
        rmr_write(5'h10);
        lines(20);
        expect_st("r52_20", M_R52 | M_INT, st(0, 0, 0, 2'd0, 6'd20));
        line(16, 6, 1'b1, 4);
        line(16, 6, 1'b1, 4);
        expect_st("vs20_l2", M_R52 | M_INT | M_VSO, st(0, 1, 0, 2'd0, 6'd0));
        repeat (4) line(16, 6, 1'b0, 4);
        expect_st("vs20_l6", M_R52 | M_INT | M_VSO, st(0, 0, 0, 2'd0, 6'd4));
        lines(47);
        expect_st("vs20_51", M_R52 | M_INT, st(0, 0, 0, 2'd0, 6'd51));
        lines(1);
        expect_st("vs20_52_int", M_R52 | M_INT, st(0, 0, 1, 2'd0, 6'd0));

        // Ack with bit5 set, RMR clear, clear coinciding with terminal count
        lines(45);
        expect_st("r52_45", M_R52 | M_INT, st(0, 0, 1, 2'd0, 6'd45));
        irq_ack();
        expect_st("ack45", M_R52 | M_INT, st(0, 0, 0, 2'd0, 6'd13));
        rmr_write(5'h10);
        expect_st("rmr_clr13", M_R52 | M_INT, st(0, 0, 0, 2'd0, 6'd0));
        lines(51);
        expect_st("pre_coincide", M_R52 | M_INT, st(0, 0, 0, 2'd0, 6'd51));
        pulse_q.push_back({4'(HS_DELAY), 4'd4});
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
        tick_rmr(1'b0, 1'b0, 5'h10);
        expect_st("coincide_clr", M_R52 | M_INT, st(0, 0, 0, 2'd0, 6'd0));
        for (int i = 7; i < 16; i++) tick(1'b0, 1'b0);
        expect_st("coincide_after", M_R52 | M_INT, st(0, 0, 0, 2'd0, 6'd0));

        // Mode latch at HSYNC_OUT rise
        line(16, 6, 1'b0, 4);
        rmr_write(5'h02);
        expect_st("mode_pending", M_MODE | M_R52, st(0, 0, 0, 2'd0, 6'd1));
        pulse_q.push_back({4'(HS_DELAY), 4'd4});
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        expect_st("mode_before_hso", M_MODE | M_HSO, st(0, 0, 0, 2'd0, 6'd0));
        tick(1'b1, 1'b0);
        expect_st("mode_at_hso", M_MODE | M_HSO, st(1, 0, 0, 2'd2, 6'd0));
        for (int i = 3; i < 16; i++) tick(i < 6, 1'b0);
        expect_st("mode_line_end", M_MODE | M_R52, st(0, 0, 0, 2'd2, 6'd2));
        rmr_write(5'h03);
        repeat (8) tick(1'b0, 1'b0);
        expect_st("mode_no_hsync", M_MODE, st(0, 0, 0, 2'd2, 6'd0));

        // Reset during VSYNC_OUT
        line(16, 6, 1'b1, 4);
        expect_st("pre_rst_l1", M_MODE | M_R52, st(0, 0, 0, 2'd3, 6'd3));
        line(16, 6, 1'b1, 4);
        line(16, 6, 1'b0, 4);
        expect_st("pre_rst_l3", M_ALL, st(0, 1, 0, 2'd3, 6'd1));
        @(posedge CLOCK); #2;
        RESET = 1'b1;
        expect_st("reset_mid", M_ALL, st(0, 0, 0, 2'd0, 6'd0));
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        line(16, 6, 1'b0, 4);
        expect_st("post_rst_line", M_ALL, st(0, 0, 0, 2'd0, 6'd1));

        repeat (4) @(negedge CLOCK);
        checks++;
        if (pulse_q.size() != 0) begin
            failures++;
            $display("FAIL hso_missing: %0d expected pulses never seen, want 0", pulse_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
